// File: rtl/ptl_tx_scheduler.sv
// ptl_tx_scheduler
// Round-robin arbiter that shares one PTL transmitter among N_REQ requesters.
// A grant toggles the transmitter drive tx_a, which is one SFQ pulse request.
// After each toggle a hold-off window keeps toggles at least GAP cycles apart,
// so the transmitter's critical-timing window is never violated.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   en       : new grants permitted
//   req      : level request per requester, one pulse wanted
//   gnt      : one-cycle grant pulse, at most one bit set
//   tx_a     : transmitter drive, each toggle is one pulse
//   busy     : hold-off window active
//   sent_cnt : total pulses issued, wraps silently
//   last_id  : index of the most recent grant
module ptl_tx_scheduler #(
    parameter int N_REQ = 4,
    parameter int GAP   = 3,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     tx_a,
    output logic                     busy,
    output logic [CNT_W-1:0]         sent_cnt,
    output logic [$clog2(N_REQ)-1:0] last_id
);

    localparam int              ID_W      = $clog2(N_REQ);
    localparam logic [7:0]      HOLD_INIT = 8'(GAP - 1);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(N_REQ - 1);

    // Registered state
    logic [7:0]       hold_cnt_r;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  last_id_r;
    logic [CNT_W-1:0] sent_cnt_r;
    logic             tx_a_r;
    logic [N_REQ-1:0] gnt_r;

    // Combinational next-state
    logic [N_REQ-1:0] elig_s;
    logic             found_s;
    logic [ID_W-1:0]  win_s;
    logic [ID_W-1:0]  idx_s;
    logic             grant_s;
    logic [N_REQ-1:0] gnt_nxt_s;
    logic [ID_W-1:0]  ptr_nxt_s;
    logic [7:0]       hold_nxt_s;

    // Round-robin search from ptr; a requester granted last cycle is masked so
    // a req that drops one cycle late cannot be granted twice.
    always_comb begin
        elig_s  = req & ~gnt_r;
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = ID_W'((32'(ptr_r) + 32'(k)) % 32'(N_REQ));
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Grant decision, one-hot grant vector, pointer advance and hold-off count
    always_comb begin
        grant_s   = en && (hold_cnt_r == 8'd0) && found_s;
        gnt_nxt_s = '0;
        if (grant_s) begin
            gnt_nxt_s[win_s] = 1'b1;
        end else begin
            gnt_nxt_s = '0;
        end

        if (win_s == LAST_IDX) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + ID_W'(1);
        end

        if (grant_s) begin
            hold_nxt_s = HOLD_INIT;
        end else if (hold_cnt_r != 8'd0) begin
            hold_nxt_s = hold_cnt_r - 8'd1;
        end else begin
            hold_nxt_s = 8'd0;
        end
    end

    // State register; reset abandons any hold-off window immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
            ptr_r      <= '0;
            last_id_r  <= '0;
            sent_cnt_r <= '0;
            tx_a_r     <= 1'b0;
            gnt_r      <= '0;
        end else begin
            gnt_r      <= gnt_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            if (grant_s) begin
                tx_a_r     <= ~tx_a_r;
                last_id_r  <= win_s;
                ptr_r      <= ptr_nxt_s;
                sent_cnt_r <= sent_cnt_r + CNT_W'(1);
            end else begin
                tx_a_r     <= tx_a_r;
                last_id_r  <= last_id_r;
                ptr_r      <= ptr_r;
                sent_cnt_r <= sent_cnt_r;
            end
        end
    end

    assign gnt      = gnt_r;
    assign tx_a     = tx_a_r;
    assign busy     = (hold_cnt_r != 8'd0);
    assign sent_cnt = sent_cnt_r;
    assign last_id  = last_id_r;

endmodule

// File: tb/tb_ptl_tx_scheduler.sv
// Bench for ptl_tx_scheduler: three instances with different GAP / CNT_W
// settings share one clock; each is compared every cycle against a reference
// model that tracks grant times and grant counts rather than counters.
module tb_ptl_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: GAP=3, CNT_W=16
    logic       rst_n_a, en_a, tx_a_a, busy_a;
    logic [3:0] req_a, gnt_a;
    logic [15:0] sent_a;
    logic [1:0] last_a;
    // Instance B: GAP=1, CNT_W=4
    logic       rst_n_b, en_b, tx_a_b, busy_b;
    logic [3:0] req_b, gnt_b;
    logic [3:0] sent_b;
    logic [1:0] last_b;
    // Instance C: GAP=4, CNT_W=16
    logic       rst_n_c, en_c, tx_a_c, busy_c;
    logic [3:0] req_c, gnt_c;
    logic [15:0] sent_c;
    logic [1:0] last_c;

    ptl_tx_scheduler #(.N_REQ(4), .GAP(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .req(req_a), .gnt(gnt_a),
        .tx_a(tx_a_a), .busy(busy_a), .sent_cnt(sent_a), .last_id(last_a));
    ptl_tx_scheduler #(.N_REQ(4), .GAP(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .req(req_b), .gnt(gnt_b),
        .tx_a(tx_a_b), .busy(busy_b), .sent_cnt(sent_b), .last_id(last_b));
    ptl_tx_scheduler #(.N_REQ(4), .GAP(4), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .en(en_c), .req(req_c), .gnt(gnt_c),
        .tx_a(tx_a_c), .busy(busy_c), .sent_cnt(sent_c), .last_id(last_c));

    int checks   = 0;
    int failures = 0;

    // Reference state: edge count since reset, time and index of last grant,
    // total grants, and the grant vector produced at the latest edge.
    typedef struct packed {
        int       e;
        int       last_e;
        bit       have_g;
        int       win;
        int       count;
        logic [3:0] gnt;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.e = 0; m.last_e = 0; m.have_g = 1'b0; m.win = 0; m.count = 0; m.gnt = 4'b0000;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] rq, input logic enable, input int gap);
        mdl_t n;
        int   e, ptr, w, idx;
        bit   free;
        n    = m;
        e    = m.e + 1;
        free = !m.have_g || ((e - m.last_e) >= gap);
        ptr  = m.have_g ? ((m.win + 1) % 4) : 0;
        w    = -1;
        if (enable && free) begin
            for (int k = 0; k < 4; k++) begin
                idx = (ptr + k) % 4;
                if (w < 0 && rq[idx] && !(m.have_g && m.last_e == e - 1 && m.win == idx))
                    w = idx;
            end
        end
        n.e = e;
        if (w >= 0) begin
            n.have_g = 1'b1;
            n.last_e = e;
            n.win    = w;
            n.count  = m.count + 1;
            n.gnt    = 4'(1 << w);
        end else begin
            n.gnt    = 4'b0000;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input mdl_t m, input int gap, input int cw,
                             input logic [3:0] g, input logic t, input logic b,
                             input logic [15:0] s, input logic [1:0] l);
        logic exp_busy;
        logic [31:0] exp_sent;
        exp_busy = m.have_g && ((m.e - m.last_e + 1) < gap);
        exp_sent = 32'(m.count) & ((32'd1 << cw) - 32'd1);
        chk({nm, ".gnt"},     32'(g), 32'(m.gnt));
        chk({nm, ".tx_a"},    32'(t), 32'(m.count & 1));
        chk({nm, ".busy"},    32'(b), 32'(exp_busy));
        chk({nm, ".sent"},    32'(s), exp_sent);
        chk({nm, ".last_id"}, 32'(l), m.have_g ? 32'(m.win) : 32'd0);
    endtask

    task automatic check_all();
        check_dut("a", ma, 3, 16, gnt_a, tx_a_a, busy_a, sent_a, last_a);
        check_dut("b", mb, 1, 4,  gnt_b, tx_a_b, busy_b, {12'd0, sent_b}, last_b);
        check_dut("c", mc, 4, 16, gnt_c, tx_a_c, busy_c, sent_c, last_c);
    endtask

    // One clock edge: advance the models with the inputs present at the edge,
    // then sample 1 time unit later.
    task automatic tick();
        if (rst_n_a) ma = mdl_step(ma, req_a, en_a, 3);
        if (rst_n_b) mb = mdl_step(mb, req_b, en_b, 1);
        if (rst_n_c) mc = mdl_step(mc, req_c, en_c, 4);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic async_reset_all();
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        #1;
        ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
        check_all();
        #2;
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] seq_b [5];
    logic [3:0] exp_seq [5];

    initial begin
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        req_a = 4'b0000; req_b = 4'b0000; req_c = 4'b0000;
        ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset.tx_a", 32'(tx_a_a), 32'd0);
        chk("reset.busy", 32'(busy_a), 32'd0);
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;

        // Held requests: GAP=3 single req, GAP=1 all req, GAP=4 then en low
        req_a = 4'b0001; en_a = 1'b1;
        req_b = 4'b1111; en_b = 1'b1;
        req_c = 4'b0011; en_c = 1'b1;
        tick();
        chk("e1.gnt_a", 32'(gnt_a), 32'd1);
        chk("e1.gnt_c", 32'(gnt_c), 32'd1);
        chk("e1.tx_a_a", 32'(tx_a_a), 32'd1);
        seq_b[0] = gnt_b;
        en_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 4) seq_b[i + 1] = gnt_b;
            if (i == 0) chk("e2.busy_a", 32'(busy_a), 32'd1);
            if (i == 1) chk("e3.busy_c", 32'(busy_c), 32'd1);
            if (i == 2) begin
                chk("e4.gnt_a", 32'(gnt_a), 32'd1);
                chk("e4.tx_a_a", 32'(tx_a_a), 32'd0);
                chk("e4.busy_c", 32'(busy_c), 32'd0);
                chk("e4.gnt_c", 32'(gnt_c), 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order[%0d]", i), 32'(seq_b[i]), 32'(exp_seq[i]));
        en_c = 1'b1;
        tick();
        chk("en_return.gnt_c", 32'(gnt_c), 32'd2);
        repeat (5) tick();
        chk("wrap17.sent_b", 32'(sent_b), 32'd1);
        chk("wrap17.tx_a_b", 32'(tx_a_b), 32'd1);

        // Single held req with GAP=1: mask gives every other edge
        req_b = 4'b0100;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("mask[%0d].gnt_b", j), 32'(gnt_b), (j % 2 == 0) ? 32'd4 : 32'd0);
        end

        // Reset in the middle of a hold-off window
        rst_n_a = 1'b0;
        #1;
        ma = mdl_reset();
        check_all();
        #2;
        rst_n_a = 1'b1;
        req_a = 4'b0001;
        tick();
        chk("pre_rst.tx_a_a", 32'(tx_a_a), 32'd1);
        chk("pre_rst.busy_a", 32'(busy_a), 32'd1);
        rst_n_a = 1'b0;
        #1;
        ma = mdl_reset();
        chk("mid_rst.tx_a_a", 32'(tx_a_a), 32'd0);
        chk("mid_rst.busy_a", 32'(busy_a), 32'd0);
        check_all();
        #2;
        rst_n_a = 1'b1;
        req_a = 4'b0011;
        tick();
        chk("post_rst.gnt_a", 32'(gnt_a), 32'd1);
        chk("post_rst.last_a", 32'(last_a), 32'd0);

        // Randomized traffic on all three instances
        for (int r = 0; r < 400; r++) begin
            req_a = 4'($urandom_range(0, 15));
            req_b = 4'($urandom_range(0, 15));
            req_c = 4'($urandom_range(0, 15));
            en_a  = ($urandom_range(0, 3) != 0);
            en_b  = ($urandom_range(0, 3) != 0);
            en_c  = ($urandom_range(0, 3) != 0);
            tick();
            if ($urandom_range(0, 39) == 0) async_reset_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
